// File: rtl/sblk_inst_sched.sv
// sblk_inst_sched: queues host instructions, issues them one at a time to the
// sblk and feeds each activation request with an exact-length burst taken from
// the upstream ready/valid activation stream.
module sblk_inst_sched #(
  parameter int N_TILE      = 4,
  parameter int WID_ACT     = 16,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TM = 3,
  parameter int WID_INST_TP = 2,
  parameter int WID_INST_LN = 3,
  parameter int WID_INST_LP = 3,
  parameter int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP + WID_INST_LN + WID_INST_LP,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk_l,
  input  logic                  rst_n,
  input  logic [WID_INST-1:0]   host_inst_data,
  input  logic                  host_inst_vld,
  output logic                  host_inst_rdy,
  input  logic [2*WID_ACT-1:0]  up_act_data,
  input  logic                  up_act_vld,
  output logic                  up_act_rdy,
  output logic [WID_INST-1:0]   inst_data,
  output logic                  inst_en,
  output logic [2*WID_ACT-1:0]  act_data_in,
  output logic                  act_data_in_vld,
  input  logic                  act_data_in_req,
  input  logic                  status_sblk,
  output logic                  sched_busy,
  output logic                  inst_done,
  output logic [15:0]           done_cnt,
  output logic                  err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  // Wide enough for the largest n_tn * n_tp * N_TILE product.
  localparam int BEATS_W = WID_INST_TN + WID_INST_TP + $clog2(N_TILE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_e;

  // Instruction queue storage and bookkeeping
  logic [WID_INST-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                rdy_en_q;
  logic                fifo_empty, fifo_full, push, pop;
  logic [WID_INST-1:0] fifo_head;

  // Scheduler state
  state_e               state_q, state_d;
  logic [WID_INST-1:0]  inst_data_q, inst_data_d;
  logic [BEATS_W-1:0]   beats_total_q, beats_total_d;
  logic [BEATS_W-1:0]   beats_left_q, beats_left_d;
  logic [2*WID_ACT-1:0] act_data_q, act_data_d;
  logic                 act_vld_q, act_vld_d;
  logic                 err_q, err_d;
  logic [15:0]          done_cnt_q, done_cnt_d;
  logic                 req_q;

  logic [WID_INST_TN-1:0] head_tn;
  logic [WID_INST_TP-1:0] head_tp;
  logic [BEATS_W-1:0]     head_beats;
  logic                   req_rise, burst_active, abort, up_hs;

  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign host_inst_rdy = rdy_en_q && !fifo_full;
  assign push          = host_inst_vld && host_inst_rdy;
  assign pop           = (state_q == S_ISSUE);
  assign fifo_head     = fifo_mem_q[rd_ptr_q];

  assign head_tn    = fifo_head[WID_INST_TN-1:0];
  assign head_tp    = fifo_head[WID_INST_TN+WID_INST_TM +: WID_INST_TP];
  assign head_beats = BEATS_W'(head_tn) * BEATS_W'(head_tp) * BEATS_W'(N_TILE);

  assign req_rise     = act_data_in_req && !req_q;
  assign burst_active = (beats_left_q != '0);
  // A falling status during a burst must cut the upstream ready in the same cycle.
  assign abort        = (state_q == S_RUN) && !status_sblk;
  assign up_act_rdy   = burst_active && !abort;
  assign up_hs        = up_act_vld && up_act_rdy;

  assign inst_data       = inst_data_q;
  assign inst_en         = (state_q == S_ISSUE);
  assign inst_done       = (state_q == S_DONE);
  assign act_data_in     = act_data_q;
  assign act_data_in_vld = act_vld_q;
  assign done_cnt        = done_cnt_q;
  assign err             = err_q;
  assign sched_busy      = (state_q != S_IDLE) || !fifo_empty;

  // Queue storage is written on push only; contents need no reset.
  always_ff @(posedge clk_l) begin
    if (push) fifo_mem_q[wr_ptr_q] <= host_inst_data;
  end

  // Queue pointers, occupancy and the delayed host-ready enable.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic for the issue FSM, the burst counter and the beat register.
  always_comb begin
    state_d       = state_q;
    inst_data_d   = inst_data_q;
    beats_total_d = beats_total_q;
    beats_left_d  = beats_left_q;
    act_data_d    = act_data_q;
    act_vld_d     = 1'b0;
    err_d         = err_q;
    done_cnt_d    = done_cnt_q;

    if (up_hs) begin
      act_data_d   = up_act_data;
      act_vld_d    = 1'b1;
      beats_left_d = beats_left_q - BEATS_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d       = S_ISSUE;
          inst_data_d   = fifo_head;
          beats_total_d = head_beats;
        end
      end
      S_ISSUE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (status_sblk) state_d = S_RUN;
      end
      S_RUN: begin
        if (!status_sblk) begin
          if (burst_active) err_d = 1'b1;
          beats_left_d = '0;
          done_cnt_d   = done_cnt_q + 16'd1;
          state_d      = S_DONE;
        end else if (req_rise && !burst_active) begin
          if (beats_total_q == '0) err_d = 1'b1;
          else beats_left_d = beats_total_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (req_rise && (state_q != S_RUN)) err_d = 1'b1;
  end

  // Scheduler registers, all cleared by reset including any in-flight burst.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inst_data_q   <= '0;
      beats_total_q <= '0;
      beats_left_q  <= '0;
      act_data_q    <= '0;
      act_vld_q     <= 1'b0;
      err_q         <= 1'b0;
      done_cnt_q    <= '0;
      req_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_data_q   <= inst_data_d;
      beats_total_q <= beats_total_d;
      beats_left_q  <= beats_left_d;
      act_data_q    <= act_data_d;
      act_vld_q     <= act_vld_d;
      err_q         <= err_d;
      done_cnt_q    <= done_cnt_d;
      req_q         <= act_data_in_req;
    end
  end

endmodule

// File: tb/tb_sblk_inst_sched.sv
// Testbench for sblk_inst_sched: plays host, upstream source and sblk, and
// compares every cycle against a queue-based reference model.
module tb_sblk_inst_sched;

  localparam int N_TILE     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;

  logic        clk_l = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] host_inst_data;
  logic        host_inst_vld;
  logic        host_inst_rdy;
  logic [31:0] up_act_data;
  logic        up_act_vld;
  logic        up_act_rdy;
  logic [13:0] inst_data;
  logic        inst_en;
  logic [31:0] act_data_in;
  logic        act_data_in_vld;
  logic        act_data_in_req;
  logic        status_sblk;
  logic        sched_busy;
  logic        inst_done;
  logic [15:0] done_cnt;
  logic        err;

  sblk_inst_sched dut (
    .clk_l(clk_l), .rst_n(rst_n),
    .host_inst_data(host_inst_data), .host_inst_vld(host_inst_vld), .host_inst_rdy(host_inst_rdy),
    .up_act_data(up_act_data), .up_act_vld(up_act_vld), .up_act_rdy(up_act_rdy),
    .inst_data(inst_data), .inst_en(inst_en),
    .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req),
    .status_sblk(status_sblk), .sched_busy(sched_busy), .inst_done(inst_done),
    .done_cnt(done_cnt), .err(err)
  );

  always #5 clk_l = ~clk_l;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          phase;
  logic [13:0] instQ[$];
  logic [13:0] expInst;
  int          curBeats;
  int          expBeatsLeft;
  logic        expErr;
  logic [15:0] expDoneCnt;
  logic        expVld;
  logic [31:0] expActData;
  logic        reqPrev;
  logic        initDone;

  int   cycleNo, lastEnCycle, lastDoneCycle, dutBeats, nServed;
  logic lastPushOk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tmoFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic modelReset();
    phase = P_IDLE;
    instQ.delete();
    expInst = '0;
    curBeats = 0;
    expBeatsLeft = 0;
    expErr = 1'b0;
    expDoneCnt = '0;
    expVld = 1'b0;
    expActData = '0;
    reqPrev = 1'b0;
    initDone = 1'b0;
  endtask

  task automatic doReset();
    host_inst_vld = 1'b0;
    up_act_vld = 1'b0;
    act_data_in_req = 1'b0;
    status_sblk = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("rst_host_rdy", host_inst_rdy, 1'b0);
    chk("rst_up_rdy", up_act_rdy, 1'b0);
    chk("rst_inst_data", inst_data, '0);
    chk("rst_inst_en", inst_en, 1'b0);
    chk("rst_act_data", act_data_in, '0);
    chk("rst_act_vld", act_data_in_vld, 1'b0);
    chk("rst_busy", sched_busy, 1'b0);
    chk("rst_inst_done", inst_done, 1'b0);
    chk("rst_done_cnt", done_cnt, '0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(posedge clk_l);
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: combinational checks before the edge, model update, registered checks after.
  task automatic step();
    logic expUpRdy, expHostRdy, hs, push, reqRise, active;
    int   oldPhase;
    @(negedge clk_l);
    expUpRdy   = (expBeatsLeft != 0) && !(phase == P_RUN && !status_sblk);
    expHostRdy = initDone && (instQ.size() < FIFO_DEPTH);
    chk("up_act_rdy", up_act_rdy, expUpRdy);
    chk("host_inst_rdy", host_inst_rdy, expHostRdy);
    hs         = up_act_vld && expUpRdy;
    push       = host_inst_vld && expHostRdy;
    lastPushOk = push;
    reqRise    = act_data_in_req && !reqPrev;
    active     = (expBeatsLeft != 0);
    oldPhase   = phase;
    reqPrev    = act_data_in_req;
    expVld     = hs;
    if (hs) begin
      expActData = up_act_data;
      expBeatsLeft--;
    end
    case (oldPhase)
      P_IDLE: begin
        if (instQ.size() != 0) begin
          phase    = P_ISSUE;
          expInst  = instQ[0];
          curBeats = int'(expInst[2:0]) * int'(expInst[7:6]) * N_TILE;
        end
      end
      P_ISSUE: begin
        void'(instQ.pop_front());
        phase = P_WAIT;
      end
      P_WAIT: if (status_sblk) phase = P_RUN;
      P_RUN: begin
        if (!status_sblk) begin
          if (active) expErr = 1'b1;
          expBeatsLeft = 0;
          expDoneCnt = expDoneCnt + 16'd1;
          phase = P_DONE;
        end else if (reqRise && !active) begin
          if (curBeats == 0) expErr = 1'b1;
          else expBeatsLeft = curBeats;
        end
      end
      default: phase = P_IDLE;
    endcase
    if (reqRise && oldPhase != P_RUN) expErr = 1'b1;
    if (push) instQ.push_back(host_inst_data);
    initDone = 1'b1;
    @(posedge clk_l);
    #2;
    cycleNo++;
    if (inst_en === 1'b1) lastEnCycle = cycleNo;
    if (inst_done === 1'b1) lastDoneCycle = cycleNo;
    if (act_data_in_vld === 1'b1) dutBeats++;
    chk("inst_en", inst_en, phase == P_ISSUE);
    chk("inst_data", inst_data, expInst);
    chk("inst_done", inst_done, phase == P_DONE);
    chk("done_cnt", done_cnt, expDoneCnt);
    chk("err", err, expErr);
    chk("act_vld", act_data_in_vld, expVld);
    chk("act_data", act_data_in, expActData);
    chk("sched_busy", sched_busy, (phase != P_IDLE) || (instQ.size() != 0));
  endtask

  task automatic pushInst(input logic [13:0] v);
    int n;
    n = 0;
    host_inst_data = v;
    host_inst_vld = 1'b1;
    do begin
      step();
      n++;
    end while (!lastPushOk && n < 50);
    host_inst_vld = 1'b0;
    if (!lastPushOk) tmoFail("push_accept");
  endtask

  function automatic logic [13:0] genInst();
    logic [2:0] tn, tm, ln, lp;
    logic [1:0] tp;
    tn = 3'($urandom_range(1, 7));
    tp = 2'($urandom_range(1, 3));
    tm = 3'($urandom);
    ln = 3'($urandom);
    lp = 3'($urandom);
    return {lp, ln, tp, tm, tn};
  endfunction

  // Act as the sblk for one instruction. stopMode: 0 normal, 1 status drop, 2 reset, after stopAt beats.
  task automatic serveInst(input int nBursts, input int vldMode, input int stopMode, input int stopAt, input int gapBusy);
    int n;
    n = 0;
    while (phase != P_WAIT && n < 50) begin
      step();
      n++;
    end
    if (phase != P_WAIT) tmoFail("wait_issue");
    repeat (gapBusy) step();
    status_sblk = 1'b1;
    step();
    for (int b = 0; b < nBursts; b++) begin
      dutBeats = 0;
      act_data_in_req = 1'b1;
      n = 0;
      do begin
        up_act_data = $urandom;
        case (vldMode)
          0:       up_act_vld = 1'b1;
          1:       up_act_vld = (n % 2 == 0);
          default: up_act_vld = 1'($urandom);
        endcase
        if (stopMode != 0 && dutBeats >= stopAt) begin
          if (stopMode == 2) begin
            doReset();
            return;
          end
          status_sblk = 1'b0;
          up_act_vld = 1'b1;
          #1;
          chk("abort_rdy", up_act_rdy, 1'b0);
          step();
          chk("abort_err", err, 1'b1);
          chk("abort_done", inst_done, 1'b1);
          act_data_in_req = 1'b0;
          up_act_vld = 1'b0;
          nServed++;
          return;
        end
        step();
        n++;
      end while ((expBeatsLeft != 0 || expVld) && n < 500);
      if (n >= 500) tmoFail("burst_end");
      act_data_in_req = 1'b0;
      up_act_vld = 1'b0;
      step();
      chk("burst_beats", dutBeats, curBeats);
    end
    status_sblk = 1'b0;
    step();
    chk("done_pulse", inst_done, 1'b1);
    nServed++;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [13:0] fullQ[5];
    int d1;
    host_inst_data = '0;
    host_inst_vld = 1'b0;
    up_act_data = '0;
    up_act_vld = 1'b0;
    act_data_in_req = 1'b0;
    status_sblk = 1'b0;
    cycleNo = 0;
    lastEnCycle = 0;
    lastDoneCycle = 0;
    dutBeats = 0;
    nServed = 0;
    lastPushOk = 1'b0;
    modelReset();
    #1;
    doReset();
    repeat (2) step();

    // Single instruction: 2*2*4 = 16 beats
    pushInst({3'd2, 3'd2, 2'd2, 3'd6, 3'd2});
    serveInst(1, 0, 0, 0, 1);
    chk("single_beats", dutBeats, 16);
    chk("single_inst_data", inst_data, 14'h12B2);
    chk("single_done_cnt", done_cnt, 16'd1);

    // Back-to-back: second instruction has 2*3*4 = 24 beats
    pushInst({3'd1, 3'd1, 2'd2, 3'd1, 3'd2});
    pushInst({3'd0, 3'd0, 2'd3, 3'd0, 3'd2});
    serveInst(1, 0, 0, 0, 0);
    d1 = lastDoneCycle;
    serveInst(1, 0, 0, 0, 0);
    chk("b2b_beats", dutBeats, 24);
    chk("b2b_gap", lastEnCycle - d1, 2);

    // Queue full: first instruction parks in WAIT_BUSY, four more fill the queue
    for (int i = 0; i < 5; i++) begin
      fullQ[i] = genInst();
      pushInst(fullQ[i]);
    end
    chk("full_rdy", host_inst_rdy, 1'b0);
    chk("full_busy", sched_busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      serveInst(1, 2, 0, 0, $urandom_range(0, 2));
      chk("fifo_order", inst_data, fullQ[i]);
    end

    // Upstream stalls: valid toggles every cycle, two bursts
    pushInst({3'd2, 3'd2, 2'd2, 3'd6, 3'd2});
    serveInst(2, 1, 0, 0, 2);
    chk("stall_beats", dutBeats, 16);

    // Random instructions and upstream valid
    for (int i = 0; i < 6; i++) begin
      pushInst(genInst());
      serveInst($urandom_range(1, 2), 2, 0, 0, $urandom_range(0, 3));
    end
    chk("clean_err", err, 1'b0);
    chk("total_done", done_cnt, nServed);

    // Stray request in IDLE
    step();
    act_data_in_req = 1'b1;
    step();
    act_data_in_req = 1'b0;
    step();
    chk("stray_err", err, 1'b1);

    // Zero-length burst: tp = 0
    doReset();
    nServed = 0;
    pushInst({3'd1, 3'd1, 2'd0, 3'd1, 3'd5});
    serveInst(1, 0, 0, 0, 0);
    chk("zero_beats", dutBeats, 0);
    chk("zero_err", err, 1'b1);

    // Abort after 5 of 16 beats
    doReset();
    pushInst({3'd2, 3'd2, 2'd2, 3'd6, 3'd2});
    serveInst(1, 0, 1, 5, 0);
    step();

    // Reset mid-burst, then recover
    pushInst({3'd2, 3'd2, 2'd2, 3'd6, 3'd2});
    serveInst(1, 0, 2, 5, 0);
    repeat (2) step();
    chk("post_rst_rdy", host_inst_rdy, 1'b1);
    pushInst({3'd0, 3'd0, 2'd1, 3'd0, 3'd1});
    serveInst(1, 0, 0, 0, 0);
    chk("post_rst_beats", dutBeats, 4);
    chk("post_rst_done_cnt", done_cnt, 16'd1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
